// File: rtl/neuron_accumulator.sv
// Single-neuron dot-product stage: accumulates bias + sum(x*w) over N_INPUTS streamed
// float pairs and offers the pre-activation sum on a valid/ready port.
module neuron_accumulator #(
  parameter int N_INPUTS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  input  logic [31:0] w,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);
  localparam int CW = $clog2(N_INPUTS + 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(N_INPUTS - 1);
  localparam logic [31:0] QNAN = 32'h7FC00000;

  // Shared single-precision multiply: round-to-nearest-even, denormal inputs/outputs as signed zero.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic               s;
    logic [47:0]        p;
    logic [24:0]        m;
    logic signed [10:0] e;
    logic               g, st, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    s      = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    p = 48'h0; m = 25'h0; e = 11'sd0; g = 1'b0; st = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      fmul = QNAN;
    end else if (a_inf || b_inf) begin
      fmul = {s, 8'hFF, 23'h0};
    end else if (a_zero || b_zero) begin
      fmul = {s, 31'h0};
    end else begin
      p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
      e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
      if (p[47]) begin
        m = {1'b0, p[47:24]}; g = p[23]; st = |p[22:0]; e = e + 11'sd1;
      end else begin
        m = {1'b0, p[46:23]}; g = p[22]; st = |p[21:0];
      end
      if (g && (st || m[0])) m = m + 25'd1;
      if (m[24]) begin m = m >> 1; e = e + 11'sd1; end
      if (e >= 11'sd255)    fmul = {s, 8'hFF, 23'h0};
      else if (e <= 11'sd0) fmul = {s, 31'h0};
      else                  fmul = {s, e[7:0], m[22:0]};
    end
  endfunction

  // Shared single-precision add: guard/round/sticky alignment, exact cancellation gives +0.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]        big, sml;
    logic [26:0]        mb, ms;
    logic [27:0]        sum;
    logic [7:0]         d;
    logic signed [10:0] e;
    logic [24:0]        m;
    logic               sticky, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    big = a; sml = b; mb = 27'h0; ms = 27'h0; sum = 28'h0; d = 8'h0;
    e = 11'sd0; m = 25'h0; sticky = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
      fadd = QNAN;
    end else if (a_inf) begin
      fadd = a;
    end else if (b_inf) begin
      fadd = b;
    end else if (a_zero && b_zero) begin
      fadd = {a[31] & b[31], 31'h0};
    end else if (a_zero) begin
      fadd = b;
    end else if (b_zero) begin
      fadd = a;
    end else begin
      if (a[30:0] < b[30:0]) begin big = b; sml = a; end
      d  = big[30:23] - sml[30:23];
      mb = {1'b1, big[22:0], 3'b000};
      ms = {1'b1, sml[22:0], 3'b000};
      if (d >= 8'd27) begin
        sticky = 1'b1; ms = 27'h0;
      end else begin
        sticky = |(ms & ((27'h1 << d) - 27'h1)); ms = ms >> d;
      end
      ms[0] = ms[0] | sticky;
      sum = (big[31] == sml[31]) ? ({1'b0, mb} + {1'b0, ms}) : ({1'b0, mb} - {1'b0, ms});
      e   = $signed({3'b000, big[30:23]});
      if (sum == 28'h0) begin
        fadd = 32'h0;
      end else begin
        if (sum[27]) begin sum = {1'b0, sum[27:2], sum[1] | sum[0]}; e = e + 11'sd1; end
        for (int i = 0; i < 26; i++) begin
          if (!sum[26]) begin sum = sum << 1; e = e - 11'sd1; end
        end
        m = {1'b0, sum[26:3]};
        if (sum[2] && ((|sum[1:0]) || m[0])) m = m + 25'd1;
        if (m[24]) begin m = m >> 1; e = e + 11'sd1; end
        if (e >= 11'sd255)    fadd = {big[31], 8'hFF, 23'h0};
        else if (e <= 11'sd0) fadd = {big[31], 31'h0};
        else                  fadd = {big[31], e[7:0], m[22:0]};
      end
    end
  endfunction

  logic [1:0]    r_state;
  logic [31:0]   r_acc;
  logic [CW-1:0] r_count;
  logic [31:0]   w_prod;
  logic [31:0]   w_sum;

  assign w_prod = fmul(x, w);
  assign w_sum  = fadd(r_acc, w_prod);

  // Control FSM, running sum and pair counter; start only matters in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= 32'h0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= bias;
            r_count <= '0;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            r_acc   <= w_sum;
            r_count <= r_count + CW'(1);
            if (r_count == LAST) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_ACCUM);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = (r_state == S_DONE) ? r_acc : 32'h0;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Bench for neuron_accumulator: directed vector table, hand-written hazard sequences and
// random evaluations checked against a real-arithmetic reference of bias + sum(x*w).
module tb_neuron_accumulator;
  localparam int N = 4;

  typedef struct {
    logic [31:0]        b;
    logic [N-1:0][31:0] xs;     // xs[0] is sent first
    logic [N-1:0][31:0] ws;
    logic [15:0]        vpat;   // in_valid per cycle, LSB first; 1 once exhausted
    int                 hold;   // cycles out_ready is held low in DONE
    bit                 poke;   // pulse start during ACCUM, DONE and on the handshake
    logic [31:0]        exp;
    int                 exp_lat; // -1 skips the latency comparison
  } vec_t;

  localparam logic [N-1:0][31:0] XS_BASIC = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
  localparam logic [N-1:0][31:0] XS_CANC  = {32'hC0000000, 32'h40000000, 32'hBF800000, 32'h3F800000};
  localparam logic [N-1:0][31:0] XS_INF   = {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7F800000};
  localparam logic [N-1:0][31:0] W_HALF   = {4{32'h3F000000}};
  localparam logic [N-1:0][31:0] W_NEG    = {4{32'hBF800000}};
  localparam logic [N-1:0][31:0] W_ONE    = {4{32'h3F800000}};
  localparam logic [N-1:0][31:0] W_ZERO0  = {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00000000};
  localparam logic [N-1:0][31:0] W_TWO0   = {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000};

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] bias, x, w, result;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  neuron_accumulator #(.N_INPUTS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .w(w),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Exactly representable real -> single-precision bits (normal range only).
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd1023 + 11'd127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  task automatic run_eval(input string nm, input vec_t v, output logic [31:0] res);
    int          idx, cyc, bitn;
    logic [31:0] held;
    res = 32'hDEADBEEF;
    @(negedge clk);
    bias = v.b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; bias = 32'h0; cyc = 1; idx = 0; bitn = 0;
    check({nm, " in_ready"}, {31'h0, in_ready}, 32'h1);
    while (!out_valid && cyc < 100) begin
      check({nm, " busy accum"}, {31'h0, busy}, 32'h1);
      in_valid = (bitn >= 16) ? 1'b1 : v.vpat[bitn];
      bitn++;
      if (idx < N) begin x = v.xs[idx]; w = v.ws[idx]; end
      if (v.poke && cyc == 2) begin start = 1'b1; bias = 32'h42C80000; end
      @(negedge clk);
      start = 1'b0;
      if (in_valid) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      check({nm, " timeout"}, 32'h0, 32'h1);
      return;
    end
    if (v.exp_lat >= 0) check({nm, " latency"}, cyc, v.exp_lat);
    held = result;
    for (int k = 0; k < v.hold; k++) begin
      out_ready = 1'b0;
      if (v.poke && k == 0) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({nm, " hold valid"}, {31'h0, out_valid}, 32'h1);
      check({nm, " hold result"}, result, held);
    end
    res = result;
    out_ready = 1'b1;
    if (v.poke) start = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0;
    check({nm, " out_valid drop"}, {31'h0, out_valid}, 32'h0);
    check({nm, " idle busy"}, {31'h0, busy}, 32'h0);
    check({nm, " idle result"}, result, 32'h0);
  endtask

  initial begin
    vec_t        tbl[6];
    vec_t        rv;
    logic [31:0] got;
    real         acc_r;
    int          kb, kx, kw;

    tbl[0] = '{b:32'h3F000000, xs:XS_BASIC, ws:W_HALF, vpat:16'hFFFF, hold:0, poke:1'b0,
               exp:32'h40B00000, exp_lat:5};
    tbl[1] = '{b:32'h00000000, xs:XS_BASIC, ws:W_NEG,  vpat:16'hFFFF, hold:0, poke:1'b0,
               exp:32'hC1200000, exp_lat:5};
    tbl[2] = '{b:32'h00000000, xs:XS_CANC,  ws:W_ONE,  vpat:16'hFFFF, hold:1, poke:1'b0,
               exp:32'h00000000, exp_lat:5};
    tbl[3] = '{b:32'h3F000000, xs:XS_BASIC, ws:W_HALF, vpat:16'hFF59, hold:3, poke:1'b1,
               exp:32'h40B00000, exp_lat:8};
    tbl[4] = '{b:32'h3F800000, xs:XS_INF,   ws:W_ZERO0, vpat:16'hFFFF, hold:0, poke:1'b0,
               exp:32'h7FC00000, exp_lat:5};
    tbl[5] = '{b:32'h3F800000, xs:XS_INF,   ws:W_TWO0,  vpat:16'hFFFF, hold:2, poke:1'b1,
               exp:32'h7F800000, exp_lat:5};

    rst = 1'b1; start = 1'b0; bias = 32'h0; in_valid = 1'b0; x = 32'h0; w = 32'h0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset in_ready", {31'h0, in_ready}, 32'h0);
    check("reset out_valid", {31'h0, out_valid}, 32'h0);
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset result", result, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_eval($sformatf("vec%0d", i), tbl[i], got);
      check($sformatf("vec%0d result", i), got, tbl[i].exp);
    end

    // Abort after two accepted pairs; the next run must carry no residue.
    @(negedge clk);
    start = 1'b1; bias = 32'h3F000000;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; x = 32'h3F800000; w = 32'h3F000000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", {31'h0, busy}, 32'h0);
    check("abort in_ready", {31'h0, in_ready}, 32'h0);
    check("abort out_valid", {31'h0, out_valid}, 32'h0);
    check("abort result", result, 32'h0);
    rst = 1'b0; in_valid = 1'b0;
    run_eval("post-abort", tbl[0], got);
    check("post-abort result", got, 32'h40B00000);

    // rst and start together: reset wins, nothing starts.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; bias = 32'h3F800000;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst+start busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    check("rst+start still idle", {31'h0, busy}, 32'h0);

    // Random evaluations on half-integer operands, exact in single precision.
    for (int t = 0; t < 25; t++) begin
      kb    = int'($urandom_range(32, 0)) - 16;
      acc_r = kb / 2.0;
      rv.b  = r2f(acc_r);
      for (int i = 0; i < N; i++) begin
        kx       = int'($urandom_range(32, 0)) - 16;
        kw       = int'($urandom_range(32, 0)) - 16;
        rv.xs[i] = r2f(kx / 2.0);
        rv.ws[i] = r2f(kw / 2.0);
        acc_r    = acc_r + (kx / 2.0) * (kw / 2.0);
      end
      rv.vpat    = 16'($urandom);
      rv.hold    = int'($urandom_range(3, 0));
      rv.poke    = 1'($urandom_range(1, 0));
      rv.exp     = r2f(acc_r);
      rv.exp_lat = -1;
      run_eval($sformatf("rand%0d", t), rv, got);
      check($sformatf("rand%0d result", t), got, rv.exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/neuron_accumulator.md
Name: neuron_accumulator

Overview:
Sequential single-neuron dot-product stage sitting directly upstream of the ReLU/Sigmoid activation blocks. It streams N_INPUTS IEEE-754 single-precision (input, weight) pairs over a valid/ready handshake and accumulates bias + sum(x*w) one pair per cycle. It presents the 32-bit pre-activation sum on a valid/ready output port that feeds the activation `num` input directly. It uses the codebase's combinational single-precision float multiplier and float adder; no new float arithmetic is written here.

Parameters:
N_INPUTS, 4, number of (x, w) pairs per neuron evaluation; legal range >= 1.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins an evaluation, sampled only in IDLE
bias  input  32  float bias; sampled on the accepted start cycle
in_valid  input  1  x/w pair present
in_ready  output  1  block accepts a pair this cycle
x  input  32  float input activation
w  input  32  float weight
out_valid  output  1  result holds a finished sum
out_ready  input  1  downstream accepts result
result  output  32  float pre-activation sum
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- FSM states: IDLE, ACCUM, DONE.
- Reset values: state=IDLE, acc=32'h00000000, count=0, in_ready=0, out_valid=0, result=0, busy=0.
- IDLE: on start=1, load acc<=bias and count<=0, then go to ACCUM. start is ignored in every other state.
- ACCUM: in_ready=1 (registered-state decode, combinational from state only; does not depend on in_valid).
  - Transfer occurs when in_valid && in_ready. On a transfer: acc<=fadd(acc, fmul(x, w)) and count<=count+1.
  - No transfer means no change; in_valid gaps of any length are allowed.
  - When the transfer with count==N_INPUTS-1 occurs, go to DONE.
  - Counter width is $clog2(N_INPUTS+1). The counter never wraps.
- DONE: out_valid=1 and result=acc. Hold both stable while out_ready=0. When out_valid && out_ready, go to IDLE on the next edge; out_valid then drops.
  - A start asserted in the same cycle as the output handshake is ignored; it must be re-pulsed in IDLE.
- result drives acc only in DONE and is 0 otherwise. Downstream may sample it only when out_valid=1.
- Latency: out_valid rises on the edge after the last accepted pair. Best case is N_INPUTS+1 cycles from start to out_valid.
- Arithmetic: accumulation order is fixed: bias first, then pairs in arrival order.
  - Special values (NaN, inf, inf*0, denormals, -0) follow the shared mul/add units bit-exactly. No extra rounding or flushing is done here.
- Reset mid-operation (any state): abort immediately to the reset values. Partial sums are discarded and no out_valid pulse is produced.
- Simultaneous rst and start: rst wins.
- N_INPUTS=1: a single transfer goes ACCUM to DONE.

Test Plan:
- Basic dot product: bias=0x3F000000 (0.5), x={1,2,3,4} (0x3F800000, 0x40000000, 0x40400000, 0x40800000), w=all 0x3F000000, in_valid continuous, out_ready=1 -> out_valid exactly 5 cycles after start, result=0x40B00000 (5.5). Downstream ReLU output also equals 0x40B00000.
- Negative sum: bias=0, same x, w=all 0xBF800000 (-1.0) -> result=0xC1200000 (-10.0). Downstream ReLU gives 0x00000000.
- Cancellation: bias=0, x={1,-1,2,-2}, w=all 1.0 -> result=0x00000000 or 0x80000000 exactly as the adder yields. busy=1 from the cycle after start until the output handshake completes.
- Backpressure:
  - in_valid toggled 1,0,0,1,1,0,1 delivers the same pairs as the basic case -> result 0x40B00000 after the 4th transfer only.
  - With out_ready held low for 3 cycles -> out_valid and result stay stable for those cycles; the block returns to IDLE one cycle after out_ready=1.
- Control hazards:
  - start pulsed during ACCUM and DONE -> ignored.
  - rst asserted after 2 accepted pairs -> next cycle state is IDLE, out_valid=0, busy=0, in_ready=0.
  - A following clean run of the basic case -> 0x40B00000 with no residue from the aborted run.
